// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run controller.
//   state_t        : controller FSM state encoding
//   ADDR_W / CNT_W : start-address and cycle-counter widths
//   DEF_*          : default parameter values (program addresses, limits)
package run_ctrl_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CNT_W  = 16;

  localparam int unsigned        DEF_NUM_PROGS   = 3;
  localparam int unsigned        DEF_INIT_CYCLES = 2;
  localparam logic [CNT_W-1:0]   DEF_MAX_CYCLES  = 16'd50000;

  localparam logic [ADDR_W-1:0]  DEF_PROG0_ADDR  = 10'd0;
  localparam logic [ADDR_W-1:0]  DEF_PROG1_ADDR  = 10'd256;
  localparam logic [ADDR_W-1:0]  DEF_PROG2_ADDR  = 10'd512;
  localparam logic [ADDR_W-1:0]  DEF_PROG3_ADDR  = 10'd768;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LAUNCH,
    S_RUN,
    S_DONE,
    S_FAULT
  } state_t;

endpackage

// File: rtl/run_controller_if.sv
// Host/core signal bundle for run_controller.
//   Inputs to the controller : Start, ProgSel[1:0], Abort, Clear, CoreAck
//   Outputs of the controller: CoreReset, CoreStart, StartAddr[9:0],
//                              Busy, Done, Timeout, CycleCount[15:0]
//   master modport: host/core side; slave modport: the controller.
interface run_controller_if;
  import run_ctrl_pkg::*;

  logic              Start;
  logic [1:0]        ProgSel;
  logic              Abort;
  logic              Clear;
  logic              CoreAck;
  logic              CoreReset;
  logic              CoreStart;
  logic [ADDR_W-1:0] StartAddr;
  logic              Busy;
  logic              Done;
  logic              Timeout;
  logic [CNT_W-1:0]  CycleCount;

  modport master (
    output Start, ProgSel, Abort, Clear, CoreAck,
    input  CoreReset, CoreStart, StartAddr, Busy, Done, Timeout, CycleCount
  );

  modport slave (
    input  Start, ProgSel, Abort, Clear, CoreAck,
    output CoreReset, CoreStart, StartAddr, Busy, Done, Timeout, CycleCount
  );

endinterface

// File: rtl/prog_addr_lut.sv
// Maps a 2-bit program index to its 10-bit start address (combinational).
//   idx_i  : program index
//   addr_o : start address for that program
module prog_addr_lut
  import run_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PROG0_ADDR = DEF_PROG0_ADDR,
  parameter logic [ADDR_W-1:0] PROG1_ADDR = DEF_PROG1_ADDR,
  parameter logic [ADDR_W-1:0] PROG2_ADDR = DEF_PROG2_ADDR,
  parameter logic [ADDR_W-1:0] PROG3_ADDR = DEF_PROG3_ADDR
) (
  input  logic [1:0]        idx_i,
  output logic [ADDR_W-1:0] addr_o
);

  always_comb begin
    addr_o = PROG0_ADDR;
    case (idx_i)
      2'd1:    addr_o = PROG1_ADDR;
      2'd2:    addr_o = PROG2_ADDR;
      2'd3:    addr_o = PROG3_ADDR;
      default: addr_o = PROG0_ADDR;
    endcase
  end

endmodule

// File: rtl/run_controller.sv
// Sequences a processor through reset, launch and run for a host-selected
// program, with a RUN-cycle watchdog.
//   Clk, Reset : clock, synchronous active-high reset
//   bus.slave  : Start/ProgSel/Abort/Clear/CoreAck in;
//                CoreReset/CoreStart/StartAddr/Busy/Done/Timeout/CycleCount out
// Every output is a flop; output flags are decoded from the next state so
// they line up with the registered state.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned       NUM_PROGS   = DEF_NUM_PROGS,
  parameter int unsigned       INIT_CYCLES = DEF_INIT_CYCLES,
  parameter logic [CNT_W-1:0]  MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter logic [ADDR_W-1:0] PROG0_ADDR  = DEF_PROG0_ADDR,
  parameter logic [ADDR_W-1:0] PROG1_ADDR  = DEF_PROG1_ADDR,
  parameter logic [ADDR_W-1:0] PROG2_ADDR  = DEF_PROG2_ADDR,
  parameter logic [ADDR_W-1:0] PROG3_ADDR  = DEF_PROG3_ADDR
) (
  input  logic             Clk,
  input  logic             Reset,
  run_controller_if.slave  bus
);

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              core_reset_q, core_reset_d;
  logic              core_start_q, core_start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] lut_addr;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              start_ok;

  assign start_ok = bus.Start && ({30'd0, bus.ProgSel} < NUM_PROGS);
  assign cnt_inc  = cnt_q + 16'd1;

  // Looked up from the index being latched this cycle so StartAddr is
  // already valid on the first INIT cycle.
  prog_addr_lut #(
    .PROG0_ADDR (PROG0_ADDR),
    .PROG1_ADDR (PROG1_ADDR),
    .PROG2_ADDR (PROG2_ADDR),
    .PROG3_ADDR (PROG3_ADDR)
  ) u_lut (
    .idx_i  (idx_d),
    .addr_o (lut_addr)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    init_cnt_d = init_cnt_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d    = S_INIT;
          idx_d      = bus.ProgSel;
          init_cnt_d = '0;
          cnt_d      = '0;
        end
      end
      S_INIT: begin
        if (bus.Abort)                    state_d = S_IDLE;
        else if (init_cnt_q == INIT_LAST) state_d = S_LAUNCH;
        else                              init_cnt_d = init_cnt_q + 4'd1;
      end
      S_LAUNCH: begin
        if (bus.Abort) state_d = S_IDLE;
        else           state_d = S_RUN;
      end
      S_RUN: begin
        // Abort beats CoreAck, CoreAck beats the watchdog; the count is
        // frozen on abort and includes the final cycle otherwise.
        if (bus.Abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (bus.CoreAck)                state_d = S_DONE;
          else if (cnt_inc == MAX_CYCLES) state_d = S_FAULT;
        end
      end
      S_DONE: begin
        if (bus.Clear) begin
          state_d = S_IDLE;
        end else if (start_ok) begin
          state_d    = S_INIT;
          idx_d      = bus.ProgSel;
          init_cnt_d = '0;
          cnt_d      = '0;
        end
      end
      S_FAULT: begin
        if (bus.Clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    core_reset_d = (state_d == S_IDLE) || (state_d == S_INIT);
    core_start_d = (state_d == S_LAUNCH);
    busy_d       = (state_d == S_INIT) || (state_d == S_LAUNCH) || (state_d == S_RUN);
    done_d       = (state_d == S_DONE);
    timeout_d    = (state_d == S_FAULT);
    addr_d       = (state_d == S_INIT) ? lut_addr : addr_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      init_cnt_q   <= '0;
      cnt_q        <= '0;
      core_reset_q <= 1'b1;
      core_start_q <= 1'b0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      init_cnt_q   <= init_cnt_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
      core_start_q <= core_start_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.CoreReset  = core_reset_q;
  assign bus.CoreStart  = core_start_q;
  assign bus.StartAddr  = addr_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.Timeout    = timeout_q;
  assign bus.CycleCount = cnt_q;

endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  run_controller_if bus ();

  run_controller #(
    .NUM_PROGS   (3),
    .INIT_CYCLES (2),
    .MAX_CYCLES  (16'd20)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        done;
    logic        timeout;
    logic        core_reset;
    logic [15:0] count;
    logic [9:0]  addr;
    int          init_cyc;
    int          starts;
    int          run_cyc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Drives one run from IDLE/DONE and observes it until Busy drops.
  // ack_at/abort_at/reset_at name the RUN cycle (1-based) on which that
  // input is raised; 0 means never.
  task automatic drive_run(input logic [1:0] sel, input int ack_at, input int abort_at,
                           input int reset_at, output int init_cyc, output int starts,
                           output int run_cyc, output logic [9:0] first_addr,
                           output logic [15:0] first_cnt, output bit ended);
    bit in_run;
    init_cyc = 0; starts = 0; run_cyc = 0; ended = 0;
    bus.Start = 1'b1; bus.ProgSel = sel;
    step();
    bus.Start = 1'b0;
    first_addr = bus.StartAddr;
    first_cnt  = bus.CycleCount;
    for (int i = 0; i < 200 && !ended; i++) begin
      if (!bus.Busy) begin
        ended = 1;
      end else begin
        in_run = 0;
        if (bus.CoreReset)      init_cyc++;
        else if (bus.CoreStart) starts++;
        else begin run_cyc++; in_run = 1; end
        bus.CoreAck = in_run && ack_at > 0 && run_cyc == ack_at;
        bus.Abort   = in_run && abort_at > 0 && run_cyc == abort_at;
        Reset       = in_run && reset_at > 0 && run_cyc == reset_at;
        step();
      end
    end
    bus.CoreAck = 1'b0; bus.Abort = 1'b0; Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step(); step();
    n_chk++; if (bus.CoreReset !== 1'b1) begin n_fail++; $display("FAIL reset_core_reset: got %b want 1", bus.CoreReset); end
    n_chk++; if (bus.CoreStart !== 1'b0) begin n_fail++; $display("FAIL reset_core_start: got %b want 0", bus.CoreStart); end
    n_chk++; if (bus.StartAddr !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.StartAddr); end
    n_chk++; if ({bus.Busy, bus.Done, bus.Timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.Busy, bus.Done, bus.Timeout}); end
    n_chk++; if (bus.CycleCount !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.CycleCount); end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    exp_t e; int ic, st, rc; logic [9:0] fa; logic [15:0] fc; bit ended;
    sb.push_back('{done:1'b1, timeout:1'b0, core_reset:1'b0, count:16'd10, addr:10'd256,
                   init_cyc:2, starts:1, run_cyc:10});
    drive_run(2'd1, 10, 0, 0, ic, st, rc, fa, fc, ended);
    e = sb.pop_front();
    n_chk++; if (ended !== 1'b1) begin n_fail++; $display("FAIL nominal_ended: got %b want 1", ended); end
    n_chk++; if (ic !== e.init_cyc) begin n_fail++; $display("FAIL nominal_init_cycles: got %0d want %0d", ic, e.init_cyc); end
    n_chk++; if (st !== e.starts) begin n_fail++; $display("FAIL nominal_start_pulses: got %0d want %0d", st, e.starts); end
    n_chk++; if (rc !== e.run_cyc) begin n_fail++; $display("FAIL nominal_run_cycles: got %0d want %0d", rc, e.run_cyc); end
    n_chk++; if (fa !== e.addr) begin n_fail++; $display("FAIL nominal_init_addr: got %0d want %0d", fa, e.addr); end
    n_chk++; if ({bus.Done, bus.Timeout} !== {e.done, e.timeout}) begin n_fail++; $display("FAIL nominal_flags: got %b want %b", {bus.Done, bus.Timeout}, {e.done, e.timeout}); end
    n_chk++; if (bus.CoreReset !== e.core_reset) begin n_fail++; $display("FAIL nominal_core_reset: got %b want %b", bus.CoreReset, e.core_reset); end
    n_chk++; if (bus.CycleCount !== e.count) begin n_fail++; $display("FAIL nominal_count: got %0d want %0d", bus.CycleCount, e.count); end
    n_chk++; if (bus.StartAddr !== e.addr) begin n_fail++; $display("FAIL nominal_addr: got %0d want %0d", bus.StartAddr, e.addr); end
    bus.Clear = 1'b1; step(); bus.Clear = 1'b0;
    n_chk++; if ({bus.Done, bus.CoreReset, bus.Busy} !== 3'b010) begin n_fail++; $display("FAIL nominal_clear: got %b want 010", {bus.Done, bus.CoreReset, bus.Busy}); end
  endtask

  task automatic test_watchdog();
    exp_t e; int ic, st, rc; logic [9:0] fa; logic [15:0] fc; bit ended;
    sb.push_back('{done:1'b0, timeout:1'b1, core_reset:1'b0, count:16'd20, addr:10'd0,
                   init_cyc:2, starts:1, run_cyc:20});
    drive_run(2'd0, 0, 0, 0, ic, st, rc, fa, fc, ended);
    e = sb.pop_front();
    n_chk++; if (ended !== 1'b1) begin n_fail++; $display("FAIL wdog_ended: got %b want 1", ended); end
    n_chk++; if (rc !== e.run_cyc) begin n_fail++; $display("FAIL wdog_run_cycles: got %0d want %0d", rc, e.run_cyc); end
    n_chk++; if ({bus.Done, bus.Timeout} !== {e.done, e.timeout}) begin n_fail++; $display("FAIL wdog_flags: got %b want %b", {bus.Done, bus.Timeout}, {e.done, e.timeout}); end
    n_chk++; if (bus.CycleCount !== e.count) begin n_fail++; $display("FAIL wdog_count: got %0d want %0d", bus.CycleCount, e.count); end
    n_chk++; if (bus.CoreReset !== e.core_reset) begin n_fail++; $display("FAIL wdog_core_reset: got %b want %b", bus.CoreReset, e.core_reset); end
    bus.Start = 1'b1; bus.ProgSel = 2'd1; step(); bus.Start = 1'b0; step();
    n_chk++; if ({bus.Busy, bus.Timeout} !== 2'b01) begin n_fail++; $display("FAIL wdog_start_ignored: got %b want 01", {bus.Busy, bus.Timeout}); end
    n_chk++; if (bus.CycleCount !== 16'd20) begin n_fail++; $display("FAIL wdog_count_held: got %0d want 20", bus.CycleCount); end
    bus.Clear = 1'b1; step(); bus.Clear = 1'b0;
    n_chk++; if ({bus.Timeout, bus.CoreReset, bus.Busy} !== 3'b010) begin n_fail++; $display("FAIL wdog_clear: got %b want 010", {bus.Timeout, bus.CoreReset, bus.Busy}); end
  endtask

  task automatic test_ack_at_limit();
    exp_t e; int ic, st, rc; logic [9:0] fa; logic [15:0] fc; bit ended;
    sb.push_back('{done:1'b1, timeout:1'b0, core_reset:1'b0, count:16'd20, addr:10'd512,
                   init_cyc:2, starts:1, run_cyc:20});
    drive_run(2'd2, 20, 0, 0, ic, st, rc, fa, fc, ended);
    e = sb.pop_front();
    n_chk++; if (ended !== 1'b1) begin n_fail++; $display("FAIL limit_ended: got %b want 1", ended); end
    n_chk++; if ({bus.Done, bus.Timeout} !== {e.done, e.timeout}) begin n_fail++; $display("FAIL limit_flags: got %b want %b", {bus.Done, bus.Timeout}, {e.done, e.timeout}); end
    n_chk++; if (bus.CycleCount !== e.count) begin n_fail++; $display("FAIL limit_count: got %0d want %0d", bus.CycleCount, e.count); end
    n_chk++; if (bus.StartAddr !== e.addr) begin n_fail++; $display("FAIL limit_addr: got %0d want %0d", bus.StartAddr, e.addr); end
    bus.Clear = 1'b1; step(); bus.Clear = 1'b0;
  endtask

  task automatic test_abort();
    exp_t e; int ic, st, rc; logic [9:0] fa; logic [15:0] fc; bit ended;
    sb.push_back('{done:1'b0, timeout:1'b0, core_reset:1'b1, count:16'd0, addr:10'd0,
                   init_cyc:2, starts:1, run_cyc:5});
    drive_run(2'd0, 5, 5, 0, ic, st, rc, fa, fc, ended);
    e = sb.pop_front();
    n_chk++; if (ended !== 1'b1) begin n_fail++; $display("FAIL abort_ended: got %b want 1", ended); end
    n_chk++; if (rc !== e.run_cyc) begin n_fail++; $display("FAIL abort_run_cycles: got %0d want %0d", rc, e.run_cyc); end
    n_chk++; if ({bus.Done, bus.Timeout} !== {e.done, e.timeout}) begin n_fail++; $display("FAIL abort_flags: got %b want %b", {bus.Done, bus.Timeout}, {e.done, e.timeout}); end
    n_chk++; if (bus.CoreReset !== e.core_reset) begin n_fail++; $display("FAIL abort_core_reset: got %b want %b", bus.CoreReset, e.core_reset); end
    bus.Start = 1'b1; bus.ProgSel = 2'd3; step(); step(); bus.Start = 1'b0; step();
    n_chk++; if ({bus.Busy, bus.CoreReset} !== 2'b01) begin n_fail++; $display("FAIL bad_progsel_ignored: got %b want 01", {bus.Busy, bus.CoreReset}); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int ic, st, rc; logic [9:0] fa; logic [15:0] fc; bit ended;
    sb.push_back('{done:1'b1, timeout:1'b0, core_reset:1'b0, count:16'd3, addr:10'd256,
                   init_cyc:2, starts:1, run_cyc:3});
    sb.push_back('{done:1'b1, timeout:1'b0, core_reset:1'b0, count:16'd4, addr:10'd512,
                   init_cyc:2, starts:1, run_cyc:4});
    drive_run(2'd1, 3, 0, 0, ic, st, rc, fa, fc, ended);
    e = sb.pop_front();
    n_chk++; if ({ended, bus.Done} !== {1'b1, e.done}) begin n_fail++; $display("FAIL b2b_first_done: got %b want %b", {ended, bus.Done}, {1'b1, e.done}); end
    n_chk++; if (bus.CycleCount !== e.count) begin n_fail++; $display("FAIL b2b_first_count: got %0d want %0d", bus.CycleCount, e.count); end
    bus.Abort = 1'b1; bus.CoreAck = 1'b1; step(); bus.Abort = 1'b0; bus.CoreAck = 1'b0;
    n_chk++; if ({bus.Done, bus.Busy} !== 2'b10) begin n_fail++; $display("FAIL b2b_abort_in_done: got %b want 10", {bus.Done, bus.Busy}); end
    drive_run(2'd2, 4, 0, 0, ic, st, rc, fa, fc, ended);
    e = sb.pop_front();
    n_chk++; if (fa !== e.addr) begin n_fail++; $display("FAIL b2b_init_addr: got %0d want %0d", fa, e.addr); end
    n_chk++; if (fc !== 16'd0) begin n_fail++; $display("FAIL b2b_init_count: got %0d want 0", fc); end
    n_chk++; if (ic !== e.init_cyc) begin n_fail++; $display("FAIL b2b_init_cycles: got %0d want %0d", ic, e.init_cyc); end
    n_chk++; if ({ended, bus.Done} !== {1'b1, e.done}) begin n_fail++; $display("FAIL b2b_second_done: got %b want %b", {ended, bus.Done}, {1'b1, e.done}); end
    n_chk++; if (bus.CycleCount !== e.count) begin n_fail++; $display("FAIL b2b_second_count: got %0d want %0d", bus.CycleCount, e.count); end
    bus.Start = 1'b1; bus.Clear = 1'b1; bus.ProgSel = 2'd0; step();
    bus.Start = 1'b0; bus.Clear = 1'b0;
    n_chk++; if ({bus.Busy, bus.Done, bus.CoreReset} !== 3'b001) begin n_fail++; $display("FAIL b2b_clear_wins: got %b want 001", {bus.Busy, bus.Done, bus.CoreReset}); end
    step();
    n_chk++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stays_idle: got %b want 0", bus.Busy); end
  endtask

  task automatic test_reset_mid_run();
    exp_t e; int ic, st, rc; logic [9:0] fa; logic [15:0] fc; bit ended;
    sb.push_back('{done:1'b0, timeout:1'b0, core_reset:1'b1, count:16'd0, addr:10'd0,
                   init_cyc:2, starts:1, run_cyc:7});
    drive_run(2'd1, 0, 0, 7, ic, st, rc, fa, fc, ended);
    e = sb.pop_front();
    n_chk++; if ({ended, rc} !== {1'b1, e.run_cyc}) begin n_fail++; $display("FAIL rst_run_end: got %b/%0d want 1/%0d", ended, rc, e.run_cyc); end
    n_chk++; if (bus.CoreReset !== e.core_reset) begin n_fail++; $display("FAIL rst_core_reset: got %b want %b", bus.CoreReset, e.core_reset); end
    n_chk++; if ({bus.CoreStart, bus.Done, bus.Timeout} !== {1'b0, e.done, e.timeout}) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {bus.CoreStart, bus.Done, bus.Timeout}); end
    n_chk++; if (bus.StartAddr !== e.addr) begin n_fail++; $display("FAIL rst_addr: got %0d want %0d", bus.StartAddr, e.addr); end
    n_chk++; if (bus.CycleCount !== e.count) begin n_fail++; $display("FAIL rst_count: got %0d want %0d", bus.CycleCount, e.count); end
    bus.CoreAck = 1'b1; repeat (3) step(); bus.CoreAck = 1'b0;
    n_chk++; if ({bus.Done, bus.Busy, bus.CycleCount} !== {2'b00, 16'd0}) begin n_fail++; $display("FAIL rst_late_ack: got %b/%b/%0d want 0/0/0", bus.Done, bus.Busy, bus.CycleCount); end
  endtask

  initial begin
    bus.Start = 1'b0; bus.ProgSel = 2'd0; bus.Abort = 1'b0;
    bus.Clear = 1'b0; bus.CoreAck = 1'b0;
    test_reset();
    test_nominal();
    test_watchdog();
    test_ack_at_limit();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter NUM_PROGS, 3, number of selectable programs (1..4).
REQ-002 SHALL have parameter INIT_CYCLES, 2, cycles CoreReset is held in INIT (1..15).
REQ-003 SHALL have parameter MAX_CYCLES, 16'd50000, RUN-cycle watchdog limit (1..65535).
REQ-004 SHALL have parameters PROG0_ADDR, PROG1_ADDR, PROG2_ADDR, PROG3_ADDR, defaults 10'd0 / 10'd256 / 10'd512 / 10'd768, program start addresses.
REQ-005 Clk  input  1  single clock; all state changes on posedge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Start  input  1  host request to run the program selected by ProgSel.
REQ-008 ProgSel  input  2  program index, sampled only with an accepted Start.
REQ-009 Abort  input  1  host cancel of an active run.
REQ-010 Clear  input  1  host acknowledge; clears DONE/FAULT.
REQ-011 CoreAck  input  1  processor done flag.
REQ-012 CoreReset  output  1  processor reset, active-high.
REQ-013 CoreStart  output  1  processor start pulse.
REQ-014 StartAddr  output  10  start PC for the latched program.
REQ-015 Busy, Done, Timeout  output  1 each  status flags.
REQ-016 CycleCount  output  16  RUN cycles of the current/last run.

Function
REQ-017 States IDLE, INIT, LAUNCH, RUN, DONE, FAULT; all outputs registered, no input-to-output combinational path.
REQ-018 IDLE: CoreReset=1, Busy=0; Start=1 with ProgSel<NUM_PROGS -> INIT, latch ProgSel, CycleCount<=0; Start with ProgSel>=NUM_PROGS ignored (stay IDLE).
REQ-019 INIT: CoreReset=1, Busy=1, StartAddr=PROGn_ADDR of latched index; exactly INIT_CYCLES cycles, then LAUNCH.
REQ-020 LAUNCH: CoreReset=0, CoreStart=1 for exactly one cycle, then RUN.
REQ-021 RUN: CycleCount increments by 1 each cycle; CoreAck=1 -> DONE, count frozen at value including the Ack cycle.
REQ-022 RUN: CycleCount reaching MAX_CYCLES without CoreAck -> FAULT, Timeout=1; CoreAck in the same cycle wins (DONE).
REQ-023 CycleCount never exceeds MAX_CYCLES; no wrap-around.
REQ-024 DONE: Done=1, Busy=0, CoreReset=0 (core state readable); Clear -> IDLE; Start with valid ProgSel -> INIT directly; Clear and Start together -> IDLE (Clear wins).
REQ-025 FAULT: Timeout=1, Busy=0, CoreReset=0; only Clear -> IDLE; Start ignored.
REQ-026 Abort in INIT, LAUNCH or RUN -> IDLE next cycle with CoreReset=1, Done=0, Timeout=0; Abort has priority over CoreAck and watchdog; Abort ignored in IDLE, DONE, FAULT.
REQ-027 CoreAck ignored outside RUN; Start ignored in INIT, LAUNCH, RUN.
REQ-028 Busy=1 exactly in INIT, LAUNCH, RUN.

Reset
REQ-029 Reset=1 forces IDLE next edge, overriding every input and any in-progress run.
REQ-030 Reset values: CoreReset=1, CoreStart=0, StartAddr=0, Busy=0, Done=0, Timeout=0, CycleCount=0, latched index=0.

Structure
REQ-031 Package run_ctrl_pkg SHALL hold the state enum and the default address/limit constants.
REQ-032 Sub-module prog_addr_lut SHALL map the 2-bit index to the 10-bit start address (combinational, registered in the parent).
REQ-033 Implementation SHALL be 120-400 lines of RTL, one FSM plus counters.

Verification
REQ-034 Start, ProgSel=1; CoreAck raised on 10th RUN cycle -> CoreReset high 2 cycles, StartAddr=256, one CoreStart pulse, Done=1, CycleCount=10.
REQ-035 MAX_CYCLES=20, no CoreAck -> Timeout=1 and CycleCount=20 after 20 RUN cycles; Start ignored; Clear -> IDLE.
REQ-036 CoreAck and watchdog expiry on the same cycle (MAX_CYCLES=20, Ack on cycle 20) -> Done=1, Timeout=0, CycleCount=20.
REQ-037 Abort on RUN cycle 5 together with CoreAck -> IDLE, CoreReset=1, Done=0; Start, ProgSel=3 with NUM_PROGS=3 -> stays IDLE.
REQ-038 In DONE, Start with ProgSel=2 -> INIT, StartAddr=512, CycleCount=0; Start+Clear together -> IDLE.
REQ-039 Reset asserted mid-RUN (cycle 7) -> all outputs at reset values next cycle; later CoreAck has no effect.
